mem32_bridge: RTL
=================

Name: mem32_bridge

Overview:
- Upstream adapter in front of the 16-bit cache/SDRAM path (memcache).
- Accepts 32-bit word read/write requests from the CPU load/store unit.
- Splits each request into one or two sequential halfword transactions on the memcache request/data_valid handshake, reassembles read data, and returns a single-cycle completion pulse.
- Holds all memcache-side inputs stable for the full duration of each halfword transaction.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles to wait for mc_data_valid per halfword; used only with MEM32_BRIDGE_TIMEOUT_EN. Counter width 8 bits; legal range 1..255.

Ports:
- clk  in  1  system clock, single domain
- reset  in  1  synchronous, active-low reset
- cpu_req  in  1  request strobe, sampled only in IDLE
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  32  byte address; bits [1:0] ignored (word aligned)
- cpu_wstrb  in  4  byte enables for writes; bit n = byte n
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- cpu_busy  out  1  high from accept until the cycle cpu_ready pulses, inclusive
- cpu_err  out  1  one-cycle pulse coincident with cpu_ready on timeout; constant 0 without the macro
- mc_ce  out  1  memcache chip enable; equals mc_rw_req
- mc_rw_req  out  1  memcache request
- mc_rw  out  1  1=write
- mc_address  out  32  halfword byte address
- mc_be  out  2  halfword byte enables
- mc_write_data  out  16  halfword write data
- mc_read_data  in  16  memcache read data, valid when mc_data_valid=1
- mc_data_valid  in  1  one-cycle memcache completion pulse

Behaviour:
- Reset (reset=0 at posedge clk): state=IDLE; all outputs 0; latched request registers 0. Reset mid-transaction aborts with no cpu_ready pulse. memcache shares this reset.
- All outputs are registered.
- In IDLE with cpu_req=1: latch cpu_we, cpu_addr[31:2], cpu_wstrb, and cpu_wdata; cpu_busy=1 from the next cycle. cpu_req in any other state is ignored.
- Half selection:
  - Read: both halves always, low first.
  - Write: low half only if wstrb[1:0]!=0; high half only if wstrb[3:2]!=0.
  - wstrb=0 write: no memcache access; go to DONE on the next cycle.
- States:
  - IDLE -> LO (low needed) | HI (write, high only) | DONE (wstrb=0).
  - LO: mc_rw_req=1; mc_address={addr[31:2],2'b00}; mc_be=read?2'b11:wstrb[1:0]; mc_write_data=wdata[15:0]. On mc_data_valid: capture mc_read_data into rdata[15:0] for reads; go to GAP if high needed, else DONE.
  - GAP: mc_rw_req=0 for exactly one cycle, so memcache sees the request drop before re-arming from its IDLE. Then go to HI.
  - HI: mc_rw_req=1; mc_address={addr[31:2],2'b10}; mc_be=read?2'b11:wstrb[3:2]; mc_write_data=wdata[31:16]. On mc_data_valid: capture into rdata[31:16] for reads; go to DONE.
  - DONE: cpu_ready=1 for one cycle; cpu_rdata valid; mc_rw_req=0 -> IDLE. A new cpu_req is accepted earliest on the cycle after DONE.
- mc_rw_req deasserts on the cycle after mc_data_valid is sampled. mc_address, mc_be, mc_rw, and mc_write_data are stable for the entire LO or HI period.
- mc_data_valid outside LO/HI is ignored.
- cpu_rdata holds its last value between transactions. Write transactions leave cpu_rdata unchanged.
- Latency = memcache latency per half + 1 (GAP, two-half accesses only) + 2 (accept, DONE). Not fixed: memcache may miss and stream a page.

Optional Feature:
- Macro: MEM32_BRIDGE_TIMEOUT_EN.
- Defined:
  - 8-bit wait counter clears on entry to LO/HI and increments each cycle without mc_data_valid.
  - At count==TIMEOUT_CYCLES: drop mc_rw_req; go to DONE with cpu_err=1 alongside cpu_ready.
  - Uncaptured rdata halves read as 16'h0000. A pending high half is skipped.
  - mc_data_valid arriving in the same cycle as the limit wins: normal completion.
- Undefined: no counter logic; cpu_err tied 0; the bridge waits indefinitely.

Test Plan:
1. Read 0x0000_1004, memcache returns 0x1234 (low) then 0xABCD (high) -> mc_address 0x1004 then 0x1006, mc_be=11 both, one GAP cycle between, cpu_rdata=0xABCD1234 with a single cpu_ready pulse.
2. Write 0x0000_2000, wdata=0xCAFEF00D, wstrb=4'b1111 -> two mc_rw=1 transactions, data 0xF00D/be 11 then 0xCAFE/be 11, one cpu_ready.
3. Write wstrb=4'b0100 to 0x0000_2000 -> single transaction at 0x2002, mc_be=01, mc_write_data=wdata[31:16]; wstrb=4'b0000 -> no mc_rw_req, cpu_ready 2 cycles after cpu_req.
4. Hold cpu_req high continuously with memcache data_valid delayed 40 cycles (miss) -> mc_rw_req and mc_address stable for 40 cycles, no second request accepted until after DONE, mc_rw_req low the cycle after mc_data_valid.
5. Assert reset=0 during HI wait -> next cycle all outputs 0, state IDLE, no cpu_ready; a fresh read afterwards completes normally.
6. MEM32_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=8, mc_data_valid never asserted on a read -> mc_rw_req drops after 8 wait cycles, cpu_ready=cpu_err=1, cpu_rdata=0x00000000, high half not issued.

Source files
------------

// File: rtl/mem32_bridge.sv
// 32-bit CPU word port onto the 16-bit memcache request/data_valid handshake.
// Optional wait timeout is enabled with `define MEM32_BRIDGE_TIMEOUT_EN.
module mem32_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_wstrb,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_busy,
    output logic        cpu_err,
    output logic        mc_ce,
    output logic        mc_rw_req,
    output logic        mc_rw,
    output logic [31:0] mc_address,
    output logic [1:0]  mc_be,
    output logic [15:0] mc_write_data,
    input  logic [15:0] mc_read_data,
    input  logic        mc_data_valid
);

    typedef enum logic [2:0] {S_IDLE, S_LO, S_GAP, S_HI, S_DONE} state_t;

    state_t      state;
    logic        we_q;
    logic [29:0] addr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [15:0] rd_lo;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem32_bridge: TIMEOUT_CYCLES must be 1..255");
    end

`ifdef MEM32_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] wait_cnt;
`endif

    // Byte offset within the word is meaningless for word accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign mc_ce = mc_rw_req;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wstrb_q       <= '0;
            wdata_q       <= '0;
            rd_lo         <= '0;
            cpu_rdata     <= '0;
            cpu_ready     <= 1'b0;
            cpu_busy      <= 1'b0;
            cpu_err       <= 1'b0;
            mc_rw_req     <= 1'b0;
            mc_rw         <= 1'b0;
            mc_address    <= '0;
            mc_be         <= '0;
            mc_write_data <= '0;
`ifdef MEM32_BRIDGE_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
        end else begin
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        we_q     <= cpu_we;
                        addr_q   <= cpu_addr[31:2];
                        wstrb_q  <= cpu_wstrb;
                        wdata_q  <= cpu_wdata;
                        cpu_busy <= 1'b1;
                        mc_rw    <= cpu_we;
`ifdef MEM32_BRIDGE_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                        if (!cpu_we || cpu_wstrb[1:0] != 2'b00) begin
                            state         <= S_LO;
                            mc_rw_req     <= 1'b1;
                            mc_address    <= {cpu_addr[31:2], 2'b00};
                            mc_be         <= cpu_we ? cpu_wstrb[1:0] : 2'b11;
                            mc_write_data <= cpu_wdata[15:0];
                        end else if (cpu_wstrb[3:2] != 2'b00) begin
                            state         <= S_HI;
                            mc_rw_req     <= 1'b1;
                            mc_address    <= {cpu_addr[31:2], 2'b10};
                            mc_be         <= cpu_wstrb[3:2];
                            mc_write_data <= cpu_wdata[31:16];
                        end else begin
                            state     <= S_DONE;
                            cpu_ready <= 1'b1;
                        end
                    end
                end

                S_LO: begin
                    if (mc_data_valid) begin
                        mc_rw_req <= 1'b0;
                        if (!we_q)
                            rd_lo <= mc_read_data;
                        if (!we_q || wstrb_q[3:2] != 2'b00) begin
                            state <= S_GAP;
                        end else begin
                            state     <= S_DONE;
                            cpu_ready <= 1'b1;
                        end
                    end
`ifdef MEM32_BRIDGE_TIMEOUT_EN
                    else if (wait_cnt == LIMIT) begin
                        mc_rw_req <= 1'b0;
                        state     <= S_DONE;
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b1;
                        if (!we_q)
                            cpu_rdata <= 32'h0000_0000;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end

                // One idle cycle lets memcache see the request drop before re-arming.
                S_GAP: begin
                    state         <= S_HI;
                    mc_rw_req     <= 1'b1;
                    mc_address    <= {addr_q, 2'b10};
                    mc_be         <= we_q ? wstrb_q[3:2] : 2'b11;
                    mc_write_data <= wdata_q[31:16];
`ifdef MEM32_BRIDGE_TIMEOUT_EN
                    wait_cnt      <= '0;
`endif
                end

                S_HI: begin
                    if (mc_data_valid) begin
                        mc_rw_req <= 1'b0;
                        state     <= S_DONE;
                        cpu_ready <= 1'b1;
                        if (!we_q)
                            cpu_rdata <= {mc_read_data, rd_lo};
                    end
`ifdef MEM32_BRIDGE_TIMEOUT_EN
                    else if (wait_cnt == LIMIT) begin
                        mc_rw_req <= 1'b0;
                        state     <= S_DONE;
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b1;
                        if (!we_q)
                            cpu_rdata <= {16'h0000, rd_lo};
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end

                S_DONE: begin
                    state    <= S_IDLE;
                    cpu_busy <= 1'b0;
                end

                default: begin
                    state     <= S_IDLE;
                    cpu_busy  <= 1'b0;
                    mc_rw_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
